stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit stream multiplexer with valid/ready handshake on every input and on the output.
- Two selection modes: software-directed select, or round-robin arbitration across requesting channels.
- Single registered output stage, so the output is timing-clean and one beat per cycle is sustained.
- Used wherever several producers share one downstream consumer; generalises the combinational 4:1 bit mux used in the building-blocks set.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DATA_W, 8, data width per channel in bits.
- SEL_W, $clog2(NUM_CH), width of sel and out_ch (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = fixed select via sel; 1 = round-robin.
- sel  in  SEL_W  channel index used when mode=0.
- in_valid  in  NUM_CH  per-channel valid.
- in_data  in  NUM_CH*DATA_W  packed channel data; channel i occupies [i*DATA_W +: DATA_W].
- in_ready  out  NUM_CH  per-channel ready.
- out_valid  out  1  output beat valid.
- out_data  out  DATA_W  output data.
- out_ch  out  SEL_W  source channel of the current output beat.
- out_ready  in  1  downstream ready.

Behaviour:
- Reset (sync, active-high, one clk edge): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready=0 while rst=1.
- Load enable: load = !out_valid || out_ready.
- Grant (combinational, at most one channel):
  - mode=0: grant channel sel if in_valid[sel]=1 and sel<NUM_CH; otherwise no grant.
  - mode=1: grant the first channel with in_valid=1, searching from rr_ptr upward and wrapping modulo NUM_CH.
- Handshakes:
  - in_ready[i] = load & grant[i] & !rst.
  - An input transfer occurs when in_valid[i] & in_ready[i].
  - in_ready must not depend on in_valid of any other channel in mode=0.
- On an input transfer: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
- If load=1 with no grant: out_valid <= 0. Otherwise the output register holds.
- Output transfer occurs when out_valid & out_ready. Simultaneous output and input transfer in the same cycle is allowed, giving full throughput with no bubble.
- Latency: 1 cycle from input transfer to out_valid.
- Round-robin pointer:
  - On each input transfer in mode=1, rr_ptr <= (g+1) mod NUM_CH, wrapping from NUM_CH-1 to 0.
  - rr_ptr does not update in mode=0 and is not cleared by mode changes.
- Mode or sel changes take effect on the next grant evaluation. A beat already held in the output register is unaffected.
- Stall (out_valid=1, out_ready=0):
  - out_data and out_ch stay stable.
  - all in_ready=0.
- sel >= NUM_CH (non-power-of-2 NUM_CH): no grant, all in_ready=0, no X propagation.
- Reset mid-operation: any held beat is discarded and the pointer returns to 0.

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN.
- When defined:
  - Adds ports in_last (in, NUM_CH) and out_last (out, 1); out_last is registered with out_data and reset to 0.
  - After a transfer with in_last=0, the grant locks to that channel (mode and sel ignored) until a transfer with in_last=1 from it.
  - rr_ptr advances only on the transfer with last=1.
  - Reset clears the lock.
- When undefined: no last ports; every beat is arbitrated independently as above.

Test Plan:
- Reset check: hold rst=1 for 3 cycles with all in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_ch=0. Release -> first beat on out after 1 cycle.
- Fixed select: mode=0, sel=2, in_valid=4'b1111, in_data ch2=8'hA5, out_ready=1 -> out_data=8'hA5 and out_ch=2 every cycle; in_ready=4'b0100.
- Round-robin fairness: mode=1, all valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with no bubbles.
- Sparse round-robin: mode=1, in_valid=4'b1010 -> out_ch alternates 1,3,1,3; channel 0 and 2 in_ready stay 0.
- Backpressure: out_ready=0 for 5 cycles with a beat held -> out_data and out_ch stable, all in_ready=0. out_ready=1 -> next channel delivered the following cycle, nothing lost or duplicated (scoreboard).
- Pkt lock (macro on): mode=1, ch1 sends 3 beats with last=0,0,1 while ch2 is valid -> out_ch=1,1,1 then 2; out_last=1 on the third beat.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux with fixed-select or round-robin grant and one output register.
// Optional packet locking (in_last/out_last ports) is enabled by defining STREAM_MUX_PKT_LOCK_EN.
module stream_mux_rr #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
`ifdef STREAM_MUX_PKT_LOCK_EN
  ,
  input  logic [NUM_CH-1:0]        in_last,
  output logic                     out_last
`endif
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              lock_q;
  logic [SEL_W-1:0]  lock_ch_q;
  logic              load, xfer, gnt_any, gnt_last;
  logic [SEL_W-1:0]  gnt_idx;
  logic [DATA_W-1:0] gnt_data;
  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [NUM_CH-1:0] ch_last;

  assign load = !out_valid_q || out_ready;
  assign xfer = load && gnt_any && !rst;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_data[gi]  = in_data[gi*DATA_W +: DATA_W];
      assign in_ready[gi] = xfer && (gnt_idx == SEL_W'(gi));
    end
  endgenerate

  // Index comparisons against each channel keep out-of-range sel from ever granting.
  always_comb begin : p_grant
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (lock_q) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (lock_ch_q == SEL_W'(i) && in_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end else if (!mode) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      // Walk the search order backwards so the last hit is the first channel from rr_ptr.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        idx = (int'(rr_ptr_q) + k) % NUM_CH;
        if (in_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin : p_gnt_mux
    gnt_data = '0;
    gnt_last = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        gnt_data = ch_data[i];
        gnt_last = ch_last[i];
      end
    end
  end

  always_comb begin : p_next
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = gnt_any;
      if (gnt_any) begin
        out_data_d = gnt_data;
        out_ch_d   = gnt_idx;
      end
    end
    if (xfer && mode && gnt_last) begin
      rr_ptr_d = (gnt_idx == SEL_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic out_last_q;

  assign ch_last = in_last;

  // A non-last beat pins the grant to its channel until that channel sends its last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_ch_q  <= '0;
      out_last_q <= 1'b0;
    end else if (xfer) begin
      lock_q     <= !gnt_last;
      lock_ch_q  <= gnt_idx;
      out_last_q <= gnt_last;
    end
  end

  assign out_last = out_last_q;
`else
  assign ch_last   = '1;
  assign lock_q    = 1'b0;
  assign lock_ch_q = '0;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: a grant model predicts in_ready and queues expected beats; a monitor checks outputs.
// Define STREAM_MUX_PKT_LOCK_EN to also exercise in_last/out_last.
module tb_stream_mux_rr;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = $clog2(N);

  logic           clk       = 1'b0;
  logic           rst       = 1'b1;
  logic           mode      = 1'b0;
  logic           out_ready = 1'b0;
  logic [SW-1:0]  sel       = '0;
  logic [N-1:0]   in_valid  = '0;
  logic [N*W-1:0] in_data   = '0;
  logic [N-1:0]   in_last   = '1;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic           out_last;
`endif

  stream_mux_rr #(.NUM_CH(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
`ifdef STREAM_MUX_PKT_LOCK_EN
    ,
    .in_last   (in_last),
    .out_last  (out_last)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int data;
    int last;
  } beat_t;

  beat_t sb[$];
  int    errors    = 0;
  int    checks    = 0;
  int    ptr_m     = 0;
  bit    occ_m     = 1'b0;
  bit    exp_valid = 1'b0;
  bit    flush     = 1'b0;
  bit    lock_m    = 1'b0;
  int    lock_ch_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus plus the reference model's view of the grant for that clock.
  task automatic step(input bit r, input bit md, input int sl, input logic [N-1:0] v,
                      input bit ordy, input logic [N-1:0] lst_v);
    int           g;
    bit           load;
    bit           lst;
    logic [N-1:0] exp_rdy;
    @(posedge clk);
    #1;
    exp_valid = occ_m;
    if (flush) begin
      sb.delete();
      flush = 1'b0;
    end
    #1;
    rst       = r;
    mode      = md;
    sel       = SW'(sl);
    in_valid  = v;
    out_ready = ordy;
    in_last   = lst_v;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
    #1;
    load = !exp_valid || ordy;
    g    = -1;
    if (lock_m) begin
      if (v[lock_ch_m]) g = lock_ch_m;
    end else if (!md) begin
      if (sl < N && v[sl]) g = sl;
    end else begin
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(ptr_m + k) % N]) g = (ptr_m + k) % N;
    end
    exp_rdy = '0;
    if (load && g >= 0 && !r) exp_rdy[g] = 1'b1;
    lst = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (g >= 0) lst = lst_v[g];
`endif
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (r) begin
      occ_m  = 1'b0;
      ptr_m  = 0;
      lock_m = 1'b0;
      flush  = 1'b1;
    end else if (load && g >= 0) begin
      sb.push_back('{g, int'(in_data[g*W +: W]), int'(lst)});
      if (md && lst) ptr_m = (g + 1) % N;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_m    = !lst;
      lock_ch_m = g;
`endif
      occ_m = 1'b1;
    end else if (load) begin
      occ_m = 1'b0;
    end
  endtask

  // Monitor: the held beat must match the queue head; it retires on out_ready.
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid && out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got beat ch=%0d data=%0h expected none at %0t", out_ch, out_data, $time);
        end else begin
          chk("out_ch", 32'(out_ch), 32'(sb[0].ch));
          chk("out_data", 32'(out_data), 32'(sb[0].data));
`ifdef STREAM_MUX_PKT_LOCK_EN
          chk("out_last", 32'(out_last), 32'(sb[0].last));
`endif
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    // Reset held with every channel requesting.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 0, 4'b1111, 1'b1, 4'b1111);
    @(negedge clk);
    #1;
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);

    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 2, 4'b1111, 1'b1, 4'b1111);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 0, 4'b1111, 1'b1, 4'b1111);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 0, 4'b1010, 1'b1, 4'b1111);

    step(1'b0, 1'b1, 0, 4'b1111, 1'b1, 4'b1111);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 0, 4'b1111, 1'b0, 4'b1111);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 0, 4'b1111, 1'b1, 4'b1111);

    // Reset mid-stream with a beat held under backpressure.
    step(1'b0, 1'b1, 0, 4'b1111, 1'b0, 4'b1111);
    step(1'b1, 1'b1, 0, 4'b1111, 1'b0, 4'b1111);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 0, 4'b1111, 1'b1, 4'b1111);

`ifdef STREAM_MUX_PKT_LOCK_EN
    step(1'b1, 1'b1, 0, 4'b0000, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 0, 4'b0110, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 0, 4'b0110, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 0, 4'b0110, 1'b1, 4'b0010);
    step(1'b0, 1'b1, 0, 4'b0110, 1'b1, 4'b0110);
`endif

    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, N - 1),
           N'($urandom), $urandom_range(0, 3) != 0, N'($urandom));
    end

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 0, 4'b0000, 1'b1, 4'b1111);
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
